control_sequencer: RTL
======================

# control_sequencer

Hardwired control unit for the simple-CPU datapath. It drives the bus-source, register-load and ALU-operation strobes for every instruction. It runs the three-cycle fetch (T0–T2), decodes the opcode in the instruction register, and steps the register-register ALU, unary and multiply/divide execute sequences. This replaces hand-sequenced control: the datapath instance connects directly to these outputs.

## Interface
Parameters:
- OPW, 5, opcode/ALU operation field width (IR[31:27])

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Run  in  1  level request to execute instructions
- MemReady  in  1  memory read data valid on Mdatain this cycle
- IR  in  32  instruction register contents from datapath
- PCout, Zlowout, Zhighout, MDRout, Rout  out  1 each  bus source strobes
- PCin, MARin, MDRin, IRin, Yin, Zin, LOin, HIin, Rin  out  1 each  register load strobes
- Gra, Grb, Grc  out  1 each  select IR ra/rb/rc field for Rin/Rout
- IncPC, Read  out  1 each  ALU PC-increment, memory read
- operation  out  OPW  ALU operation code
- Done  out  1  one-cycle pulse on instruction writeback
- Illegal  out  1  high while halted on an undefined opcode

## Operation
- The FSM uses a 4-bit state register with states IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT.
- Outputs are Moore: they decode from the state (and from IR in T3+). Every strobe not listed for a state is 0, and operation is 0 unless stated.
- IDLE: all outputs 0. Go to T0 when Run=1.
- T0: PCout, MARin, IncPC, Zin. Next state is T1.
- T1: Zlowout, PCin, Read, MDRin. Stay in T1 while MemReady=0 (strobes held); go to T2 when MemReady=1. PCin is asserted only in the cycle MemReady=1, so PC loads once.
- T2: MDRout, IRin. Next state is T3; IR is valid from T3 onward.
- Decode uses IR[31:27]:
  - Three-register: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shr, 00101 shra, 00110 shl, 00111 ror, 01000 rol.
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, operation=opcode.
    - T5: Zlowout, Gra, Rin, Done.
  - Unary: 10001 neg, 10010 not.
    - T3: Grb, Rout, Zin, operation=opcode.
    - T4: Zlowout, Gra, Rin, Done.
  - Mul/div: 01111 mul, 10000 div.
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, Zin, operation=opcode.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin, Done.
  - Any other opcode: T3 goes to HALT with no strobes. In HALT, Illegal=1 and all strobes are 0; only Reset exits.
- After the Done state: go to T0 if Run=1, else IDLE. Deasserting Run mid-instruction has no effect until the Done state.

## Timing
- Reset (sampled at a rising edge): the next state is IDLE, all outputs 0, and Illegal=0. This applies in any state, including mid-fetch, T1 wait and HALT.
- Latency from Run=1 in IDLE to the first Done, with MemReady held high: three-register is 7 edges (IDLE→T0…T5), unary 6, mul/div 8. Each wait cycle in T1 adds one.
- Back-to-back instructions with Run held: the Done state is followed directly by T0, with no IDLE bubble.
- Done is high exactly one cycle per completed instruction; it is never high in HALT or IDLE.
- operation and the Gr* selects change only on state transitions, so there are no intra-state glitches from IR, because IR loads only at the end of T2.

## Configuration
- CTRL_MULDIV_EN defined: opcodes 01111 and 10000 run the T3–T6 mul/div sequence, and LOin, HIin and Zhighout are driven.
- Undefined: 01111 and 10000 are illegal (T3 → HALT), T6 is unreachable, and LOin, HIin and Zhighout are tied to 0.

## Test plan
- Reset then Run=1, MemReady=1, IR=0x021B8000 (add R4,R3,R7):
  - T0…T5 in order.
  - T4: Grc=Rout=Zin=1, operation=00000.
  - T5: Gra=Rin=Zlowout=Done=1.
  - Next state T0.
- IR=0x321B8000 (shl R4,R3,R7): T4 operation=00110; Done 7 cycles after leaving IDLE.
- MemReady held 0 for 3 cycles in T1:
  - State stays T1 with Read=MDRin=1 and PCin=0.
  - PCin=1 only in the release cycle; T2 follows.
- IR=0x79B80000 (mul R3,R7), macro defined:
  - T5: LOin=Zlowout=1.
  - T6: HIin=Zhighout=Done=1.
  - Without the macro: HALT, Illegal=1, Done never asserted.
- IR=0xF8000000: HALT with Illegal=1 for 10 cycles despite Run=1; Reset returns IDLE with all outputs 0.
- Reset asserted in T4 of an add: IDLE on the next edge, Zin=Rout=0, R4 not written.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the simple-CPU datapath.
// Runs the T0-T2 fetch, decodes IR[31:27] and steps the register-register,
// unary and (optionally) multiply/divide execute sequences.
// Optional feature macro: CTRL_MULDIV_EN enables the mul/div (01111/10000)
// sequence and the LOin/HIin/Zhighout strobes; without it those opcodes halt.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Run,
  input  logic           MemReady,
  input  logic [31:0]    IR,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           Rout,
  output logic           PCin,
  output logic           MARin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           LOin,
  output logic           HIin,
  output logic           Rin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic [OPW-1:0] operation,
  output logic           Done,
  output logic           Illegal
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  state_t state, next_state;

  logic [4:0] opc;
  logic       is_three;
  logic       is_unary;
  logic       is_muldiv;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_three  = (opc <= 5'b01000);
  assign is_unary  = (opc == 5'b10001) || (opc == 5'b10010);
`ifdef CTRL_MULDIV_EN
  assign is_muldiv = (opc == 5'b01111) || (opc == 5'b10000);
`else
  assign is_muldiv = 1'b0;
`endif

  // State register with synchronous reset to IDLE
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and Moore strobe decode (PCin in T1 also gated by MemReady)
  always_comb begin
    next_state = state;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    Rout       = 1'b0;
    PCin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    Rin        = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    operation  = '0;
    Done       = 1'b0;
    Illegal    = 1'b0;
    case (state)
      IDLE: if (Run) next_state = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        next_state = T1;
      end
      T1: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (MemReady) begin
          PCin       = 1'b1;
          next_state = T2;
        end
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = T3;
      end
      T3: begin
        if (is_three) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          next_state = T4;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = IR[31 -: OPW];
          next_state = T4;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
          next_state = T4;
        end else begin
          next_state = HALT;
        end
      end
      T4: begin
        if (is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
          next_state = Run ? T0 : IDLE;
        end else if (is_three) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = IR[31 -: OPW];
          next_state = T5;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = IR[31 -: OPW];
          next_state = T5;
        end else begin
          next_state = HALT;
        end
      end
      T5: begin
        if (is_three) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
          next_state = Run ? T0 : IDLE;
        end else if (is_muldiv) begin
`ifdef CTRL_MULDIV_EN
          Zlowout = 1'b1; LOin = 1'b1;
`endif
          next_state = T6;
        end else begin
          next_state = HALT;
        end
      end
      T6: begin
`ifdef CTRL_MULDIV_EN
        Zhighout = 1'b1; HIin = 1'b1; Done = 1'b1;
        next_state = Run ? T0 : IDLE;
`else
        next_state = IDLE;
`endif
      end
      HALT: Illegal = 1'b1;
      default: next_state = IDLE;
    endcase
  end

endmodule
